// File: rtl/seven_segment_capture.sv
// Seven-segment bus monitor: waits for each anode/segment pair to settle, decodes it, builds frames.
// Optional decimal-point capture is enabled by defining SEG_CAPTURE_DP_EN.
module seven_segment_capture #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  anode,
    input  logic [6:0]  segment,
`ifdef SEG_CAPTURE_DP_EN
    input  logic        dp,
    output logic [3:0]  dp_flags,
`endif
    output logic [15:0] digits,
    output logic [3:0]  digit_valid,
    output logic        frame_done,
    output logic        pattern_err,
    output logic        anode_err,
    output logic [7:0]  err_count
);

    localparam logic [7:0] SettleMax  = 8'(SETTLE_CYCLES);
    localparam logic [7:0] SettleLast = 8'(SETTLE_CYCLES - 1);

    typedef enum logic {StTrack, StHeld} state_t;

    state_t      state;
    logic [3:0]  s_an;
    logic [6:0]  s_seg;
    logic [7:0]  cnt;
    logic [3:0]  seen;

    logic        changed;
    logic        capture;
    logic        idle;
    logic        single;
    logic [1:0]  idx;
    logic        blank;
    logic        hit;
    logic [3:0]  nib;
    logic        mark;
    logic [3:0]  seen_set;
    logic [7:0]  err_next;

`ifdef SEG_CAPTURE_DP_EN
    logic s_dp;
    assign changed = {anode, segment, dp} != {s_an, s_seg, s_dp};
`else
    assign changed = {anode, segment} != {s_an, s_seg};
`endif

    // Capture on the edge at which the counter would reach SETTLE_CYCLES.
    assign capture  = (state == StTrack) && !changed && (cnt >= SettleLast);
    assign idle     = (anode == 4'b1111);
    assign blank    = (segment == 7'b1111111);
    assign mark     = capture && !idle && single && (blank || hit);
    assign seen_set = seen | (4'b0001 << idx);
    assign err_next = (err_count == 8'hff) ? err_count : err_count + 8'd1;

    always_comb begin
        single = 1'b1;
        idx    = 2'd0;
        case (anode)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: single = 1'b0;
        endcase
    end

    always_comb begin
        hit = 1'b1;
        nib = 4'h0;
        case (segment)
            7'b1000000: nib = 4'h0;
            7'b1111001: nib = 4'h1;
            7'b0100100: nib = 4'h2;
            7'b0110000: nib = 4'h3;
            7'b0011001: nib = 4'h4;
            7'b0010010: nib = 4'h5;
            7'b0000010: nib = 4'h6;
            7'b1111000: nib = 4'h7;
            7'b0000000: nib = 4'h8;
            7'b0010000: nib = 4'h9;
            7'b0001000: nib = 4'ha;
            7'b0000011: nib = 4'hb;
            7'b1000110: nib = 4'hc;
            7'b0100001: nib = 4'hd;
            7'b0000110: nib = 4'he;
            7'b0001110: nib = 4'hf;
            default:    hit = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= StTrack;
            s_an        <= 4'b1111;
            s_seg       <= 7'b1111111;
            cnt         <= 8'd0;
            seen        <= 4'b0000;
            digits      <= 16'h0000;
            digit_valid <= 4'b0000;
            frame_done  <= 1'b0;
            pattern_err <= 1'b0;
            anode_err   <= 1'b0;
            err_count   <= 8'd0;
`ifdef SEG_CAPTURE_DP_EN
            s_dp        <= 1'b1;
            dp_flags    <= 4'b0000;
`endif
        end else begin
            frame_done  <= 1'b0;
            pattern_err <= 1'b0;
            anode_err   <= 1'b0;
            s_an        <= anode;
            s_seg       <= segment;
`ifdef SEG_CAPTURE_DP_EN
            s_dp        <= dp;
`endif
            if (changed) begin
                cnt <= 8'd0;
            end else if (cnt < SettleMax) begin
                cnt <= cnt + 8'd1;
            end

            case (state)
                StTrack: if (capture) state <= StHeld;
                StHeld:  if (changed) state <= StTrack;
            endcase

            if (capture && !idle) begin
                if (!single) begin
                    anode_err <= 1'b1;
                    err_count <= err_next;
                end else if (blank) begin
                    digit_valid[idx] <= 1'b0;
                end else if (hit) begin
                    digits[{idx, 2'b00} +: 4] <= nib;
                    digit_valid[idx]          <= 1'b1;
                end else begin
                    pattern_err <= 1'b1;
                    err_count   <= err_next;
                end
            end

            if (mark) begin
`ifdef SEG_CAPTURE_DP_EN
                dp_flags[idx] <= ~dp;
`endif
                if (seen_set == 4'b1111) begin
                    frame_done <= 1'b1;
                    seen       <= 4'b0000;
                end else begin
                    seen <= seen_set;
                end
            end
        end
    end

endmodule

// File: tb/tb_seven_segment_capture.sv
// Scoreboard bench for seven_segment_capture: a dwell-level model queues expected output snapshots,
// a monitor checks every cycle's outputs against the latest snapshot.
module tb_seven_segment_capture;

    localparam int unsigned S = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  anode = 4'hf;
    logic [6:0]  segment = 7'h7f;
    logic [15:0] digits;
    logic [3:0]  digit_valid;
    logic        frame_done;
    logic        pattern_err;
    logic        anode_err;
    logic [7:0]  err_count;

    seven_segment_capture #(.SETTLE_CYCLES(S)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .anode       (anode),
        .segment     (segment),
        .digits      (digits),
        .digit_valid (digit_valid),
        .frame_done  (frame_done),
        .pattern_err (pattern_err),
        .anode_err   (anode_err),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned edge_no;
        logic [15:0] digits;
        logic [3:0]  valid;
        logic        fd;
        logic        pe;
        logic        ae;
        logic [7:0]  errc;
    } exp_t;

    exp_t        q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int unsigned edge_cnt = 0;

    logic [6:0] tbl [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                             7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    // Reference model state
    logic [3:0]  m_dig [4];
    logic [3:0]  m_valid;
    logic [3:0]  m_seen;
    logic [7:0]  m_err;
    logic [10:0] prev;
    int          run;

    // Monitor: one comparison per clock, pulses expected only on queued capture edges.
    initial begin
        exp_t cur;
        logic fd, pe, ae;
        cur = '{0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h0};
        forever begin
            @(posedge clk);
            #1;
            edge_cnt++;
            fd = 1'b0;
            pe = 1'b0;
            ae = 1'b0;
            if (q.size() > 0 && q[0].edge_no == edge_cnt) begin
                cur = q.pop_front();
                fd  = cur.fd;
                pe  = cur.pe;
                ae  = cur.ae;
            end
            vectors++;
            if ({digits, digit_valid, err_count, frame_done, pattern_err, anode_err} !==
                {cur.digits, cur.valid, cur.errc, fd, pe, ae}) begin
                miscompares++;
                $display("FAIL outputs edge %0d: got digits=%h valid=%b err_count=%0d fd/pe/ae=%b%b%b, want digits=%h valid=%b err_count=%0d fd/pe/ae=%b%b%b",
                         edge_cnt, digits, digit_valid, err_count, frame_done, pattern_err,
                         anode_err, cur.digits, cur.valid, cur.errc, fd, pe, ae);
            end
        end
    end

    task automatic push(input logic fd, input logic pe, input logic ae);
        exp_t e;
        e.edge_no = edge_cnt + 1;
        e.digits  = {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
        e.valid   = m_valid;
        e.fd      = fd;
        e.pe      = pe;
        e.ae      = ae;
        e.errc    = m_err;
        q.push_back(e);
    endtask

    task automatic bump_err();
        if (m_err != 8'hff) m_err = m_err + 8'd1;
    endtask

    task automatic capture();
        logic fd, pe, ae;
        int   zeros, idx, hit;
        fd = 1'b0; pe = 1'b0; ae = 1'b0;
        zeros = 0; idx = 0; hit = -1;
        for (int i = 0; i < 4; i++) begin
            if (!anode[i]) begin
                zeros++;
                idx = i;
            end
        end
        if (zeros == 0) return;
        if (zeros > 1) begin
            ae = 1'b1;
            bump_err();
        end else if (segment == 7'h7f) begin
            m_valid[idx] = 1'b0;
            m_seen[idx]  = 1'b1;
        end else begin
            for (int n = 0; n < 16; n++) if (tbl[n] == segment) hit = n;
            if (hit < 0) begin
                pe = 1'b1;
                bump_err();
            end else begin
                m_dig[idx]   = 4'(hit);
                m_valid[idx] = 1'b1;
                m_seen[idx]  = 1'b1;
            end
        end
        if (m_seen == 4'hf) begin
            fd     = 1'b1;
            m_seen = 4'h0;
        end
        push(fd, pe, ae);
    endtask

    // Called once per upcoming edge: a pair is captured once, on its (S+1)-th consecutive edge.
    task automatic step();
        logic [10:0] v;
        v = {anode, segment};
        if (v == prev) begin
            run++;
        end else begin
            prev = v;
            run  = 1;
        end
        if (run == S + 1) capture();
    endtask

    task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int n);
        repeat (n) begin
            @(negedge clk);
            anode   = an;
            segment = seg;
            step();
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst_n   = 1'b0;
        anode   = 4'($urandom);
        segment = 7'($urandom);
        for (int i = 0; i < 4; i++) m_dig[i] = 4'h0;
        m_valid = 4'h0;
        m_seen  = 4'h0;
        m_err   = 8'h0;
        push(1'b0, 1'b0, 1'b0);
        repeat (n - 1) begin
            @(negedge clk);
            anode   = 4'($urandom);
            segment = 7'($urandom);
        end
        @(negedge clk);
        rst_n   = 1'b1;
        anode   = 4'hf;
        segment = 7'h7f;
        prev    = {4'hf, 7'h7f};
        run     = 1;
        step();
    endtask

    task automatic frame(input int a, input int b, input int c, input int d);
        drive(4'b1110, tbl[a], 8);
        drive(4'b1101, tbl[b], 8);
        drive(4'b1011, tbl[c], 8);
        drive(4'b0111, tbl[d], 8);
    endtask

    initial begin
        logic [3:0] an_opts [6];
        logic [3:0] an;
        logic [6:0] seg;
        int         r;
        an_opts = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1111, 4'b0000};

        do_reset(5);
        drive(4'hf, 7'h7f, 20);
        frame(3, 10, 0, 15);
        drive(4'b1110, tbl[2], 3);
        drive(4'hf, 7'h7f, 6);
        drive(4'b1011, 7'b1111110, 6);
        drive(4'b1100, tbl[8], 6);
        for (int i = 0; i < 300; i++) drive((i % 2 == 0) ? 4'b0011 : 4'b1100, tbl[1], 6);
        drive(4'b1101, 7'h7f, 6);
        drive(4'b1110, tbl[9], 1000);
        drive(4'b1110, tbl[1], 6);
        drive(4'b1101, tbl[2], 6);
        do_reset(3);
        drive(4'b1011, tbl[4], 8);
        drive(4'b0111, tbl[5], 8);
        frame(6, 7, 11, 12);

        for (int i = 0; i < 400; i++) begin
            r  = int'($urandom_range(0, 5));
            an = (r == 5) ? 4'($urandom) : an_opts[r];
            r  = int'($urandom_range(0, 9));
            if (r < 7)       seg = tbl[$urandom_range(0, 15)];
            else if (r == 7) seg = 7'h7f;
            else             seg = 7'($urandom);
            drive(an, seg, int'($urandom_range(1, 8)));
        end

        drive(4'hf, 7'h7f, 10);
        @(negedge clk);
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL queue_drain: got %0d pending, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seven_segment_capture.md
# seven_segment_capture

Receive-side monitor for the multiplexed seven-segment display bus. The block samples the active-low anode and cathode lines driven by the display controller and waits for each digit pattern to settle. It then decodes the cathode pattern back to a hex nibble and assembles complete 4-digit frames. It sits beside the display driver as an on-chip checker and as the bench-side model for display-driver verification.

## Interface
- SETTLE_CYCLES, 4: consecutive cycles an anode/segment pair must hold before capture; legal range 2..255.
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- anode  input  4  digit enables, active-low; anode[0] selects the rightmost digit.
- segment  input  7  cathodes, active-low; segment[0]=a … segment[6]=g.
- digits  output  16  captured nibbles; digits[4i+3:4i] holds digit i.
- digit_valid  output  4  digit i holds a decoded value (not blank).
- frame_done  output  1  one-cycle pulse when all four digits have been captured since the last pulse.
- pattern_err  output  1  one-cycle pulse when a settled segment pattern is not in the decode table.
- anode_err  output  1  one-cycle pulse when a settled anode value has more than one low bit.
- err_count  output  8  saturating count of pattern_err plus anode_err events.

## Operation
- Decode table, segment value to nibble:
  - 0: 1000000; 1: 1111001; 2: 0100100; 3: 0110000
  - 4: 0011001; 5: 0010010; 6: 0000010; 7: 1111000
  - 8: 0000000; 9: 0010000; A: 0001000; b: 0000011
  - C: 1000110; d: 0100001; E: 0000110; F: 0001110
- Sampling register: s_an and s_seg latch anode and segment every cycle.
- 8-bit stability counter:
  - Clears when {anode, segment} differs from {s_an, s_seg}.
  - Otherwise increments, saturating at SETTLE_CYCLES.
- FSM S_TRACK (reset state):
  - When the counter reaches SETTLE_CYCLES, take exactly one capture action, then go to S_HELD.
- FSM S_HELD:
  - Take no action while inputs are unchanged.
  - Any input change clears the counter and returns to S_TRACK.
  - Result: one capture per dwell, however long the dwell.
- Capture actions, by anode value:
  - All ones (1111): idle. No update, no error.
  - Exactly one zero at index i, table hit: write digits[i], set digit_valid[i], set seen[i].
  - Exactly one zero, segment is 1111111: blank. Clear digit_valid[i] and set seen[i]; digits[i] is unchanged.
  - Exactly one zero, table miss: pulse pattern_err. digits and digit_valid are unchanged; seen[i] is not set.
  - Two or more zeros: pulse anode_err. No digit update.
- Frame tracking:
  - When a capture makes seen equal 1111, pulse frame_done and clear seen in the same edge.
  - Re-capturing a digit before the frame completes overwrites it; seen is unaffected.
- err_count increments on each error pulse and saturates at 255. A pattern_err and an anode_err cannot occur in the same cycle.

## Timing
- Reset values:
  - digits = 0, digit_valid = 0000, seen = 0000.
  - frame_done = 0, pattern_err = 0, anode_err = 0, err_count = 0.
  - FSM = S_TRACK, counter = 0, s_an = 1111, s_seg = 1111111.
- Capture latency: inputs held constant from just before edge E0 produce their capture at edge E(SETTLE_CYCLES). Outputs are valid after that edge.
- A change before edge E(SETTLE_CYCLES) produces no capture; this rejects ghosting during anode transitions.
- All outputs are registered. Pulses are high for exactly one cycle.
- Back-to-back dwells of SETTLE_CYCLES+1 cycles each capture correctly.
- Reset asserted mid-dwell or mid-frame discards partial progress immediately, asynchronously.
- After rst_n deasserts, the first capture needs a full settle window.

## Configuration
- SEG_CAPTURE_DP_EN defined:
  - Adds input dp (1 bit, active-low decimal point) and output dp_flags (4 bits).
  - dp participates in the stability compare.
  - On a valid or blank capture, dp_flags[i] = ~dp.
  - dp_flags resets to 0000.
- SEG_CAPTURE_DP_EN undefined: no dp port, no dp_flags port, no dp logic.

## Test plan
- Reset: hold rst_n=0 with random inputs -> all outputs at their reset values. Release, then hold anode=1111 for 20 cycles -> no pulses, err_count=0.
- Full frame (SETTLE_CYCLES=4, dwell of 8 cycles per digit):
  - Stimulus: anode 1110/1101/1011/0111 with segment patterns for 3, A, 0, F.
  - Required: digits=16'hF0A3, digit_valid=1111, frame_done pulses once on the capture edge of digit 3.
- Short dwell: anode=1110, segment=0100100 held 3 cycles, then a different pattern -> no capture; digits[3:0] unchanged.
- Errors:
  - segment=1111110 on anode=1011 -> pattern_err pulse, err_count=1, seen[2] not set.
  - anode=1100 held 6 cycles -> anode_err pulse, err_count=2.
- Saturation and blank:
  - 300 bad dwells -> err_count=255.
  - Blank on digit 1 -> digit_valid[1]=0, digits[7:4] retained.
- Long dwell and mid-dwell reset:
  - Stable 1000 cycles -> exactly one capture.
  - rst_n pulse mid-frame -> seen cleared; next frame_done only after all four digits are recaptured.
